// File: rtl/interp_rate_ctrl.sv
// Sequencer for a zero-stuffing interpolation stage: pulls one upstream sample per
// L output slots, emits data in phase 0 and zeros elsewhere, then flushes the FIR.
module interp_rate_ctrl #(
  parameter int Win       = 16,
  parameter int RATIO_W   = 8,
  parameter int CNT_W     = 12,
  parameter int DRAIN_CYC = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [RATIO_W-1:0] ratio,
  input  logic [CNT_W-1:0]   frame_len,
  input  logic               src_valid,
  input  logic [Win-1:0]     src_data,
  output logic               src_ready,
  output logic               dp_val,
  output logic [Win-1:0]     dp_data,
  output logic [RATIO_W-1:0] phase,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic               busy,
  output logic               done,
  output logic               underrun
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_next;
  logic [RATIO_W-1:0] l_reg;
  logic [CNT_W-1:0]   len_reg;
  logic               stop_pend;
  logic [DW-1:0]      drain_cnt;
  logic               last_phase;
  logic               frame_end;
  logic               drain_last;
  logic [CNT_W-1:0]   cnt_eff;

  always_comb begin
    src_ready  = (state == RUN) && (phase == '0);
    busy       = (state != IDLE);
    last_phase = (phase == l_reg - RATIO_W'(1));
    // Count including the sample taken this cycle, so L=1 (phase 0 is also the
    // last phase) terminates after exactly frame_len samples like L>1 does.
    cnt_eff    = (phase == '0) ? sample_cnt + CNT_W'(1) : sample_cnt;
    frame_end  = last_phase &&
                 (((len_reg != '0) && (cnt_eff == len_reg)) || stop_pend || stop);
    drain_last = (drain_cnt == DW'(DRAIN_CYC - 1));
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)      state_next = RUN;
      RUN:     if (frame_end)  state_next = DRAIN;
      DRAIN:   if (drain_last) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_val     <= 1'b0;
      dp_data    <= '0;
      phase      <= '0;
      sample_cnt <= '0;
      done       <= 1'b0;
      underrun   <= 1'b0;
      l_reg      <= RATIO_W'(1);
      len_reg    <= '0;
      stop_pend  <= 1'b0;
      drain_cnt  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          dp_val  <= 1'b0;
          dp_data <= '0;
          if (start) begin
            l_reg      <= (ratio == '0) ? RATIO_W'(1) : ratio;
            len_reg    <= frame_len;
            phase      <= '0;
            sample_cnt <= '0;
            underrun   <= 1'b0;
            stop_pend  <= 1'b0;
          end
        end
        RUN: begin
          dp_val    <= 1'b1;
          dp_data   <= (src_ready && src_valid) ? src_data : '0;
          if (src_ready) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (!src_valid) underrun <= 1'b1;
          end
          phase     <= last_phase ? '0 : phase + RATIO_W'(1);
          stop_pend <= last_phase ? 1'b0 : (stop_pend | stop);
          drain_cnt <= '0;
        end
        DRAIN: begin
          dp_val    <= 1'b1;
          dp_data   <= '0;
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_last) done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interp_rate_ctrl.sv
// Directed bench for interp_rate_ctrl: table of frame scenarios plus hand-written
// reset-in-RUN and long continuous-mode sequences.
module tb_interp_rate_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, src_valid;
  logic [7:0]  ratio;
  logic [11:0] frame_len;
  logic [15:0] src_data;
  logic        src_ready, dp_val, busy, done, underrun;
  logic [15:0] dp_data;
  logic [7:0]  phase;
  logic [11:0] sample_cnt;

  int total = 0;
  int bad   = 0;

  interp_rate_ctrl #(
    .Win(16), .RATIO_W(8), .CNT_W(12), .DRAIN_CYC(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .ratio(ratio),
    .frame_len(frame_len), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .dp_val(dp_val), .dp_data(dp_data), .phase(phase),
    .sample_cnt(sample_cnt), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ratio;
    logic [11:0] len;
    int          inv;      // sample number sent with src_valid=0 (0 = none)
    int          stop_s;   // pulse stop at phase 1 of this sample (0 = none)
    bit          restart;  // pulse start during RUN and DRAIN
    int          n;        // samples expected in the frame
    int          nval;     // dp_val cycles expected
    bit          und;
    int          cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_row(input int r, input vec_t v);
    int slots = 0, nval = 0, ndone = 0, at_done = -1, errs = 0, l;
    bit fin = 1'b0;
    logic [15:0] got[$];
    logic [15:0] exp_q[$];
    l = (v.ratio == 0) ? 1 : int'(v.ratio);
    for (int i = 1; i <= v.n; i++) begin
      exp_q.push_back((i == v.inv) ? 16'h0 : 16'(i * 256));
      for (int p = 1; p < l; p++) exp_q.push_back(16'h0);
    end
    for (int i = 0; i < 32; i++) exp_q.push_back(16'h0);

    @(negedge clk);
    start = 1'b1; ratio = v.ratio; frame_len = v.len; src_valid = 1'b1; src_data = '0; stop = 1'b0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      @(negedge clk);
      start = 1'b0; ratio = v.ratio; frame_len = v.len; stop = 1'b0;
      if (k == 0) begin
        chk($sformatf("row%0d busy_after_start", r), busy, 1);
        chk($sformatf("row%0d underrun_cleared", r), underrun, 0);
        chk($sformatf("row%0d cnt_cleared", r), sample_cnt, 0);
      end
      if (dp_val) begin nval++; got.push_back(dp_data); end
      if (done) begin ndone++; at_done = nval; fin = 1'b1; end
      if (src_ready) begin
        slots++;
        src_data  = 16'(slots * 256);
        src_valid = (slots != v.inv);
      end else begin
        src_data  = 16'hBEEF;
        src_valid = 1'b1;
      end
      if (v.stop_s != 0 && phase == 8'd1 && slots == v.stop_s) stop = 1'b1;
      if (v.restart && (k == 2 || k == v.nval - 3)) begin
        start = 1'b1; ratio = 8'd3; frame_len = 12'd1;
      end
    end
    chk($sformatf("row%0d finished", r), fin, 1);
    chk($sformatf("row%0d nval", r), nval, v.nval);
    chk($sformatf("row%0d done_pulses", r), ndone, 1);
    chk($sformatf("row%0d done_on_last", r), at_done, nval);
    chk($sformatf("row%0d underrun", r), underrun, v.und);
    chk($sformatf("row%0d sample_cnt", r), sample_cnt, v.cnt);
    if (got.size() != exp_q.size()) errs = 1;
    else foreach (got[i]) if (got[i] !== exp_q[i]) errs++;
    chk($sformatf("row%0d stream_errors", r), errs, 0);
    @(negedge clk);
    chk($sformatf("row%0d idle_after", r), {dp_val, busy, done}, 0);
  endtask

  initial begin
    bit seen;
    int e_rdy, e_cnt, e_dat, e_done, n_after;
    bit saw_max, saw_wrap;
    logic [15:0] prev;

    vecs[0] = '{8'd4, 12'd3,  0, 0, 1'b0, 3, 44, 1'b0, 3};
    vecs[1] = '{8'd2, 12'd4,  2, 0, 1'b0, 4, 40, 1'b1, 4};
    vecs[2] = '{8'd4, 12'd0,  0, 5, 1'b0, 5, 52, 1'b0, 5};
    vecs[3] = '{8'd0, 12'd5,  0, 0, 1'b1, 5, 37, 1'b0, 5};
    vecs[4] = '{8'd1, 12'd1,  0, 0, 1'b0, 1, 33, 1'b0, 1};
    vecs[5] = '{8'd3, 12'd2,  1, 0, 1'b0, 2, 38, 1'b1, 2};
    vecs[6] = '{8'd4, 12'd10, 0, 2, 1'b0, 2, 40, 1'b0, 2};

    rst = 1'b1; start = 1'b0; stop = 1'b0; src_valid = 1'b0; src_data = '0;
    ratio = '0; frame_len = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {dp_val, dp_data, phase, sample_cnt, done, underrun}, 0);
    chk("reset busy_ready", {busy, src_ready}, 0);
    rst = 1'b0;

    // reset while RUN at phase 2, with underrun and sample_cnt already nonzero
    @(negedge clk);
    start = 1'b1; ratio = 8'd4; frame_len = 12'd3; src_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (phase == 8'd2) seen = 1'b1;
    end
    chk("rst_run reached_phase2", seen, 1);
    chk("rst_run pre_state", {dp_val, underrun, sample_cnt}, {1'b1, 1'b1, 12'd1});
    rst = 1'b1;
    @(negedge clk);
    chk("rst_run outputs", {dp_val, dp_data, phase, sample_cnt, done, underrun}, 0);
    chk("rst_run busy_ready", {busy, src_ready}, 0);
    rst = 1'b0; src_valid = 1'b1;

    foreach (vecs[r]) run_row(r, vecs[r]);

    // continuous mode, L=1, long enough for sample_cnt to wrap
    @(negedge clk);
    start = 1'b1; ratio = 8'd1; frame_len = 12'd0; src_valid = 1'b1; src_data = '0;
    e_rdy = 0; e_cnt = 0; e_dat = 0; e_done = 0; saw_max = 0; saw_wrap = 0; prev = '0;
    for (int j = 0; j <= 5000; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (!src_ready) e_rdy++;
      if (sample_cnt != 12'(j)) e_cnt++;
      if (j >= 1 && (!dp_val || dp_data !== prev)) e_dat++;
      if (done) e_done++;
      if (sample_cnt == 12'd4095) saw_max = 1'b1;
      if (saw_max && sample_cnt == 12'd0) saw_wrap = 1'b1;
      prev = 16'(j * 3 + 1);
      src_data = prev;
    end
    chk("cont ready_errors", e_rdy, 0);
    chk("cont count_errors", e_cnt, 0);
    chk("cont data_errors", e_dat, 0);
    chk("cont done_pulses", e_done, 0);
    chk("cont wrapped", saw_wrap, 1);

    stop = 1'b1;
    seen = 1'b0; n_after = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      stop = 1'b0;
      if (dp_val) n_after++;
      if (done) seen = 1'b1;
    end
    chk("cont stop_done", seen, 1);
    chk("cont stop_outputs", n_after, 33);
    chk("cont stop_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
